pipe_int_max: RTL and testbench
===============================

PIPE_INT_MAX -- requirements
Module: pipe_int_max

Interface
REQ-001 SHALL have parameter BW, default 8, meaning total fixed-point word width in bits (signed two's complement).
REQ-002 SHALL have parameter FW, default 2, meaning fraction bits, with 1 <= FW <= BW-2.
REQ-003 SHALL have parameter LANES, default 4, meaning elements accepted per input beat, LANES >= 1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  LANES x BW (unpacked array)  one beat of signed fixed-point elements.
REQ-007 SHALL have port in_valid  input  1  beat present.
REQ-008 SHALL have port in_last  input  1  beat is final beat of current row.
REQ-009 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-010 SHALL have port out_max  output  BW  running integer max of the row up to and including this beat, fraction bits zero.
REQ-011 SHALL have port out_first  output  1  beat was first of its row.
REQ-012 SHALL have port out_last  output  1  copy of in_last for this beat.
REQ-013 SHALL have port out_valid  output  1  output beat present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts output beat.

Function
REQ-015 SHALL transfer an input beat when in_valid and in_ready are both 1, and an output beat when out_valid and out_ready are both 1.
REQ-016 SHALL ceil each lane to an integer: clear the FW fraction bits, then add 2^FW if any cleared bit was nonzero, signed arithmetic.
REQ-017 SHALL saturate a ceiling result that would exceed the largest positive integer to that integer (sign 0, integer bits all 1, fraction 0).
REQ-018 SHALL reduce the LANES ceiled values to their signed maximum; equal values give that value.
REQ-019 SHALL be a 2-stage pipeline: stage 1 registers ceil+reduce result with first/last; stage 2 registers running max; latency 2 cycles from input transfer to out_valid with no stall.
REQ-020 SHALL set running max to the beat max on a first beat, else to signed max(running max, beat max).
REQ-021 SHALL treat as first the first beat after reset and every beat following a beat with in_last=1.
REQ-022 SHALL allow each stage to load when empty or when its contents leave in the same cycle; in_ready = stage 1 empty or stage 1 advancing.
REQ-023 SHALL hold out_max, out_first, out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain one beat per cycle when out_ready is held 1, including back-to-back rows.
REQ-025 SHALL treat a single beat with in_last=1 as a complete row: out_first=1 and out_last=1.

Reset
REQ-026 SHALL on rst=1 clear both stage valids, set out_valid=0, out_max=0, out_first=0, out_last=0, out_delta=0, and in_ready=1 from the next cycle.
REQ-027 SHALL discard any partial row on reset mid-row; the next accepted beat is first.
REQ-028 SHALL ignore in_valid during a cycle with rst=1.

Configuration
REQ-029 SHALL, with macro PIPE_INT_MAX_DELTA_EN defined, add port out_delta output BW, equal to previous running max minus new running max (<= 0), 0 on first beats, saturating at the most negative value.
REQ-030 SHALL, without PIPE_INT_MAX_DELTA_EN, omit out_delta and its logic; all other behaviour identical.

Verification
REQ-031 SHALL cover ceil/max: BW=8,FW=2,LANES=4, one beat {0x05,0x04,0xF9,0x03} last=1 -> out_max=0x08 after 2 cycles, first=1, last=1.
REQ-032 SHALL cover saturation: lane 0x7F others 0x80 -> out_max=0x7C.
REQ-033 SHALL cover running max: 3-beat row with beat maxima 0x04,0x0C,0x08 -> out_max 0x04,0x0C,0x0C; with DELTA_EN out_delta 0x00,0xF8,0x00.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles during continuous input -> in_ready drops after 2 beats buffered, no beat lost or duplicated, order preserved.
REQ-035 SHALL cover reset mid-row: rst after beat 1 of a 3-beat row, then new beat 0x10 -> out_max=0x10 with out_first=1.
REQ-036 SHALL cover back-to-back rows: last beat of row A (max 0x20) followed next cycle by row B beat max 0x04 -> row B out_max=0x04, out_first=1.

Source files
------------

// File: rtl/pipe_int_max.sv
// Two-stage fixed-point row max: stage 1 ceils every lane and reduces the beat, stage 2 keeps the
// running max of the row. Optional out_delta port enabled by macro PIPE_INT_MAX_DELTA_EN.
module pipe_int_max #(
    parameter int unsigned BW    = 8,
    parameter int unsigned FW    = 2,
    parameter int unsigned LANES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] in_data [LANES],
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [BW-1:0] out_max,
    output logic          out_first,
    output logic          out_last,
    output logic          out_valid,
`ifdef PIPE_INT_MAX_DELTA_EN
    output logic [BW-1:0] out_delta,
`endif
    input  logic          out_ready
);

    localparam logic signed [BW-1:0] MaxInt = {1'b0, {(BW-FW-1){1'b1}}, {FW{1'b0}}};
    localparam logic signed [BW:0]   OneInt = {{(BW-FW){1'b0}}, 1'b1, {FW{1'b0}}};

    // Ceil to integer in BW+1 bits; a result of the form 01xx.. has passed MaxInt.
    function automatic logic signed [BW-1:0] ceil_sat(input logic signed [BW-1:0] x);
        logic signed [BW:0] fl;
        logic signed [BW:0] r;
        fl = {x[BW-1], x[BW-1:FW], {FW{1'b0}}};
        r  = (|x[FW-1:0]) ? fl + OneInt : fl;
        if (r[BW:BW-1] == 2'b01) begin
            return MaxInt;
        end
        return r[BW-1:0];
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic signed [BW-1:0] s1_max_q, s1_max_d;
    logic                 s1_first_q, s1_first_d;
    logic                 s1_last_q, s1_last_d;
    logic                 first_pend_q, first_pend_d;
    logic                 s2_valid_q, s2_valid_d;
    logic signed [BW-1:0] run_max_q, run_max_d;
    logic                 s2_first_q, s2_first_d;
    logic                 s2_last_q, s2_last_d;

    logic                 s2_ready;
    logic                 s1_adv;
    logic                 in_xfer;
    logic signed [BW-1:0] lane_ceil [LANES];
    logic signed [BW-1:0] beat_max;
    logic signed [BW-1:0] run_next;

    always_comb begin
        beat_max = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_ceil[i] = ceil_sat($signed(in_data[i]));
        end
        beat_max = lane_ceil[0];
        for (int i = 1; i < LANES; i++) begin
            if (lane_ceil[i] > beat_max) begin
                beat_max = lane_ceil[i];
            end
        end
    end

    always_comb begin
        s2_ready = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_ready;
        in_ready = !rst && (!s1_valid_q || s2_ready);
        in_xfer  = in_valid && in_ready;

        s1_valid_d   = s1_valid_q;
        s1_max_d     = s1_max_q;
        s1_first_d   = s1_first_q;
        s1_last_d    = s1_last_q;
        first_pend_d = first_pend_q;
        if (in_xfer) begin
            s1_valid_d   = 1'b1;
            s1_max_d     = beat_max;
            s1_first_d   = first_pend_q;
            s1_last_d    = in_last;
            first_pend_d = in_last;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        run_next = s1_first_q ? s1_max_q : ((s1_max_q > run_max_q) ? s1_max_q : run_max_q);

        s2_valid_d = s2_valid_q;
        run_max_d  = run_max_q;
        s2_first_d = s2_first_q;
        s2_last_d  = s2_last_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            run_max_d  = run_next;
            s2_first_d = s1_first_q;
            s2_last_d  = s1_last_q;
        end else if (s2_valid_q && out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_max_q     <= '0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            first_pend_q <= 1'b1;
            s2_valid_q   <= 1'b0;
            run_max_q    <= '0;
            s2_first_q   <= 1'b0;
            s2_last_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_max_q     <= s1_max_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            first_pend_q <= first_pend_d;
            s2_valid_q   <= s2_valid_d;
            run_max_q    <= run_max_d;
            s2_first_q   <= s2_first_d;
            s2_last_q    <= s2_last_d;
        end
    end

    assign out_max   = run_max_q;
    assign out_first = s2_first_q;
    assign out_last  = s2_last_q;
    assign out_valid = s2_valid_q;

`ifdef PIPE_INT_MAX_DELTA_EN
    localparam logic signed [BW-1:0] MinVal = {1'b1, {(BW-1){1'b0}}};

    logic signed [BW-1:0] delta_q, delta_d;
    logic signed [BW:0]   diff;

    // Previous minus new running max is never positive; clamp below at MinVal.
    always_comb begin
        diff    = {run_max_q[BW-1], run_max_q} - {run_next[BW-1], run_next};
        delta_d = delta_q;
        if (s1_adv) begin
            if (s1_first_q) begin
                delta_d = '0;
            end else if (diff[BW:BW-1] == 2'b10) begin
                delta_d = MinVal;
            end else begin
                delta_d = diff[BW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delta_q <= '0;
        end else begin
            delta_q <= delta_d;
        end
    end

    assign out_delta = delta_q;
`endif

endmodule

// File: tb/tb_pipe_int_max.sv
// Self-checking bench for pipe_int_max: directed cases with literal expectations plus randomized
// traffic compared every cycle against a behavioural row-max model.
module tb_pipe_int_max;
    localparam int BW    = 8;
    localparam int FW    = 2;
    localparam int LANES = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] in_data [LANES];
    logic          in_valid, in_last, in_ready;
    logic [BW-1:0] out_max;
    logic          out_first, out_last, out_valid, out_ready;
`ifdef PIPE_INT_MAX_DELTA_EN
    logic [BW-1:0] out_delta;
`endif

    always #5 clk = ~clk;

    pipe_int_max #(.BW(BW), .FW(FW), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_max   (out_max),
        .out_first (out_first),
        .out_last  (out_last),
        .out_valid (out_valid),
`ifdef PIPE_INT_MAX_DELTA_EN
        .out_delta (out_delta),
`endif
        .out_ready (out_ready)
    );

    typedef struct {
        int mx;
        int first;
        int last;
        int delta;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m_first = 1;
    int    m_run = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_int(input logic [BW-1:0] x);
        int v;
        v = $signed(x);
        return v;
    endfunction

    // Mathematical ceiling of x / 2^FW, scaled back, clamped to the largest integer value.
    function automatic int ceil_lane(input logic [BW-1:0] x);
        int v, s, c, lim;
        v   = to_int(x);
        s   = 1 << FW;
        c   = (v >= 0) ? (v + s - 1) / s : -((-v) / s);
        lim = ((2 ** (BW - 1)) - 1) / s * s;
        return (c * s > lim) ? lim : c * s;
    endfunction

    // Cycle monitor: model bookkeeping, output scoreboard, in_ready and hold-stability checks.
    int hold = 0;
    int p_max, p_first, p_last, p_delta;
    always @(negedge clk) begin
        beat_t e, g;
        int    bm, nr, d;
        if (rst) begin
            exp_q.delete();
            m_first = 1;
            m_run   = 0;
            hold    = 0;
        end else begin
            check("in_ready", int'(in_ready), int'(exp_q.size() < 2 || out_ready));
            g.mx    = to_int(out_max);
            g.first = int'(out_first);
            g.last  = int'(out_last);
`ifdef PIPE_INT_MAX_DELTA_EN
            g.delta = to_int(out_delta);
`else
            g.delta = 0;
`endif
            if (hold != 0) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_max", g.mx, p_max);
                check("hold_first", g.first, p_first);
                check("hold_last", g.last, p_last);
                check("hold_delta", g.delta, p_delta);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(g);
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_max", g.mx, e.mx);
                    check("out_first", g.first, e.first);
                    check("out_last", g.last, e.last);
`ifdef PIPE_INT_MAX_DELTA_EN
                    check("out_delta", g.delta, e.delta);
`endif
                end
            end
            if (in_valid && in_ready) begin
                bm = ceil_lane(in_data[0]);
                for (int i = 1; i < LANES; i++) begin
                    if (ceil_lane(in_data[i]) > bm) bm = ceil_lane(in_data[i]);
                end
                if (m_first != 0) begin
                    nr = bm;
                    d  = 0;
                end else begin
                    nr = (bm > m_run) ? bm : m_run;
                    d  = m_run - nr;
                    if (d < -(2 ** (BW - 1))) d = -(2 ** (BW - 1));
                end
                e.mx    = nr;
                e.first = m_first;
                e.last  = int'(in_last);
                e.delta = d;
                exp_q.push_back(e);
                m_run   = nr;
                m_first = int'(in_last);
            end
            hold    = int'(out_valid && !out_ready);
            p_max   = g.mx;
            p_first = g.first;
            p_last  = g.last;
            p_delta = g.delta;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the transfer edge.
    task automatic send(input logic [31:0] w, input logic last);
        int n;
        for (int i = 0; i < LANES; i++) in_data[i] = w[i*8 +: 8];
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_got(input string name, input int idx, input int mx, input int first,
                              input int last);
        if (idx >= got_q.size()) begin
            check({name, "_missing"}, got_q.size(), idx + 1);
        end else begin
            check({name, "_max"}, got_q[idx].mx, mx);
            check({name, "_first"}, got_q[idx].first, first);
            check({name, "_last"}, got_q[idx].last, last);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < LANES; i++) in_data[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_max", to_int(out_max), 0);
        check("rst_out_first", int'(out_first), 0);
        check("rst_out_last", int'(out_last), 0);
`ifdef PIPE_INT_MAX_DELTA_EN
        check("rst_out_delta", to_int(out_delta), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Ceil and reduce, with two-cycle latency.
        got_q.delete();
        send(32'h03F90405, 1'b1);
        @(negedge clk);
        check("lat_cycle1_valid", int'(out_valid), 0);
        @(negedge clk);
        check("lat_cycle2_valid", int'(out_valid), 1);
        idle(2);
        expect_got("ceil", 0, 8, 1, 1);

        // Saturating ceiling.
        got_q.delete();
        send(32'h8080807F, 1'b1);
        idle(4);
        expect_got("sat", 0, 124, 1, 1);

        // Running max within one row.
        got_q.delete();
        send(32'h80808004, 1'b0);
        send(32'h8080800C, 1'b0);
        send(32'h80808008, 1'b1);
        idle(4);
        expect_got("run0", 0, 4, 1, 0);
        expect_got("run1", 1, 12, 0, 0);
        expect_got("run2", 2, 12, 0, 1);
`ifdef PIPE_INT_MAX_DELTA_EN
        if (got_q.size() == 3) begin
            check("run_delta0", got_q[0].delta, 0);
            check("run_delta1", got_q[1].delta, -8);
            check("run_delta2", got_q[2].delta, 0);
        end
`endif

        // Reset in the middle of a row discards it.
        got_q.delete();
        send(32'h80808020, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(32'h80808010, 1'b1);
        idle(4);
        expect_got("rstmid", 0, 16, 1, 1);
        check("rstmid_count", got_q.size(), 1);

        // Back-to-back rows.
        got_q.delete();
        send(32'h80808020, 1'b0);
        send(32'h80808008, 1'b1);
        send(32'h80808004, 1'b1);
        idle(4);
        expect_got("b2b0", 0, 32, 1, 0);
        expect_got("b2b1", 1, 32, 0, 1);
        expect_got("b2b2", 2, 4, 1, 1);

        // Backpressure: out_ready low for five cycles under continuous input.
        got_q.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send({24'h808080, 8'(4 * i)}, 1'b1);
            end
            begin
                idle(5);
                out_ready = 1'b1;
            end
        join
        idle(4);
        for (int i = 0; i < 6; i++) expect_got("bp", i, 4 * (i + 1), 1, 1);
        check("bp_count", got_q.size(), 6);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < LANES; i++) begin
                case ($urandom_range(0, 9))
                    0:       in_data[i] = 8'h7F;
                    1:       in_data[i] = 8'h80;
                    2:       in_data[i] = 8'h7D;
                    default: in_data[i] = 8'($urandom);
                endcase
            end
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            idle(1);
        end
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
